// File: rtl/fp_divider.sv
// Sequential IEEE-754 binary32 divider (out = in1 / in2), radix-2 restoring
// mantissa division one quotient bit per clock, start/done handshake.
// Ports: clk, rst (async active-high), start, in1, in2 -> busy, done (pulse),
//        out, invalid, div_zero, overflow, underflow (held until next done).
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        invalid,
  output logic        div_zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, SPECIAL, DIVIDE, ROUND
  } state_t;

  state_t             state;
  logic        [31:0] a;
  logic        [31:0] b;
  logic        [25:0] rem;
  logic        [23:0] dvs;
  logic        [25:0] quo;
  logic         [4:0] cnt;
  logic signed  [9:0] exp_q;

  // operand classification; denormals count as zero
  logic sgn;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic special;

  assign sgn    = a[31] ^ b[31];
  assign a_zero = (a[30:23] == 8'd0);
  assign a_inf  = (&a[30:23]) & ~(|a[22:0]);
  assign a_nan  = (&a[30:23]) & (|a[22:0]);
  assign b_zero = (b[30:23] == 8'd0);
  assign b_inf  = (&b[30:23]) & ~(|b[22:0]);
  assign b_nan  = (&b[30:23]) & (|b[22:0]);
  assign special = a_zero | a_inf | a_nan |
                   b_zero | b_inf | b_nan;

  logic [31:0] sp_res;
  logic        sp_inv;
  logic        sp_dz;

  always_comb begin
    sp_res = {sgn, 31'd0};
    sp_inv = 1'b0;
    sp_dz  = 1'b0;
    if (a_nan | b_nan | (a_zero & b_zero) |
        (a_inf & b_inf)) begin
      sp_res = 32'h7FC0_0000;
      sp_inv = 1'b1;
    end else if (a_inf) begin
      sp_res = {sgn, 8'hFF, 23'd0};
    end else if (b_zero) begin
      sp_res = {sgn, 8'hFF, 23'd0};
      sp_dz  = 1'b1;
    end
  end

  // one restoring step
  logic        ge;
  logic [25:0] diff;
  logic [25:0] nxt;

  assign ge   = (rem >= {2'b00, dvs});
  assign diff = rem - {2'b00, dvs};
  assign nxt  = ge ? diff : rem;

  // normalise, round-to-nearest-even, range check
  logic        [25:0] qn;
  logic signed  [9:0] en;
  logic signed  [9:0] ef;
  logic        [24:0] msum;
  logic        [22:0] man;
  logic               guard;
  logic               sticky;
  logic               inc;
  logic        [31:0] rn_res;
  logic               rn_ovf;
  logic               rn_unf;

  always_comb begin
    qn     = quo[25] ? quo : {quo[24:0], 1'b0};
    en     = quo[25] ? exp_q : exp_q - 10'sd1;
    guard  = qn[1];
    sticky = qn[0] | (rem != 26'd0);
    inc    = guard & (sticky | qn[2]);
    msum   = {1'b0, qn[25:2]} + {24'd0, inc};
    man    = msum[24] ? msum[23:1] : msum[22:0];
    ef     = msum[24] ? en + 10'sd1 : en;
    rn_ovf = 1'b0;
    rn_unf = 1'b0;
    if (ef >= 10'sd255) begin
      rn_res = {sgn, 8'hFF, 23'd0};
      rn_ovf = 1'b1;
    end else if (ef <= 10'sd0) begin
      rn_res = {sgn, 31'd0};
      rn_unf = 1'b1;
    end else begin
      rn_res = {sgn, ef[7:0], man};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      invalid   <= 1'b0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= in1;
            b     <= in2;
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (special) begin
            state <= SPECIAL;
          end else begin
            rem   <= {2'b01, a[22:0]};
            dvs   <= {1'b1, b[22:0]};
            quo   <= '0;
            cnt   <= 5'd25;
            exp_q <= $signed({2'b00, a[30:23]})
                   - $signed({2'b00, b[30:23]})
                   + 10'sd127;
            state <= DIVIDE;
          end
        end
        SPECIAL: begin
          out       <= sp_res;
          invalid   <= sp_inv;
          div_zero  <= sp_dz;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        DIVIDE: begin
          quo <= {quo[24:0], ge};
          rem <= nxt << 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= ROUND;
        end
        ROUND: begin
          out       <= rn_res;
          invalid   <= 1'b0;
          div_zero  <= 1'b0;
          overflow  <= rn_ovf;
          underflow <= rn_unf;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Sequential IEEE-754 binary32 divider: out = in1 / in2.
- It is the inverse-operation companion to the combinational FP multiplier in the FP ALU.
- The mantissa quotient comes from a radix-2 restoring divider, one quotient bit per clock, under a start/done handshake.
- Results feed the ALU result mux.
- Denormals are flushed to zero. Rounding is round-to-nearest-even.

Parameters:
- none; format fixed to binary32 (8-bit exponent, bias 127, 23-bit fraction).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- in1  in  32  dividend; captured on the accepted start edge
- in2  in  32  divisor; captured on the accepted start edge
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; out/flags valid in this cycle
- out  out  32  quotient; held until the next done
- invalid  out  1  0/0, inf/inf, or any NaN input
- div_zero  out  1  finite nonzero / zero
- overflow  out  1  result rounded to infinity
- underflow  out  1  result flushed to zero

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, done=0, out=32'h0, all flags 0; internal registers cleared.
- Reset asserted mid-operation aborts the operation; no done is produced.
- Handshake:
  - start with busy=0 captures in1/in2 on that edge.
  - start while busy=1 is ignored; inputs are not re-sampled.
  - start asserted in the same cycle as done is accepted, because busy=0 in the done cycle.
- Decode at the capture edge:
  - e=0 means zero (any fraction, flushed).
  - e=255, f=0 means inf.
  - e=255, f≠0 means NaN.
- States:
  - IDLE: on start → SPECIAL if either operand is zero/inf/NaN, else DIVIDE.
  - SPECIAL: one cycle; writes out/flags, pulses done → IDLE.
  - Special results (sign = s1^s2 unless NaN):
    - any NaN, 0/0, inf/inf → 32'h7FC00000, invalid=1.
    - nonzero/0 → signed inf, div_zero=1.
    - inf/finite → signed inf, no flag.
    - 0/nonzero → signed zero.
    - finite/inf → signed zero, no flag.
  - DIVIDE: 26 cycles, step counter 25→0.
    - Remainder R (26 bits) is initialised to {1,f1}; divisor D = {1,f2}.
    - Each step: if R≥D then q bit=1 and R=(R−D)<<1, else q bit=0 and R=R<<1.
    - Output is Q[25:0]; its MSB has weight 2^0. Counter reaching 0 → ROUND.
  - ROUND: one cycle.
    - Exponent arithmetic is 10-bit signed: E = e1 − e2 + 127.
    - If Q[25]=0: shift Q left 1 and E−1.
    - Mantissa = Q[25:2]; guard = Q[1]; sticky = Q[0] | (R≠0).
    - RNE: increment if guard & (sticky | lsb).
    - Mantissa carry-out → shift right, E+1.
    - E≥255 → signed inf, overflow=1.
    - E≤0 → signed zero, underflow=1.
    - Otherwise pack {sign, E[7:0], mantissa[22:0]}. Pulse done → IDLE.
- Latency:
  - Normal operands: done exactly 28 clocks after the accepted start edge (1 capture + 26 DIVIDE + 1 ROUND).
  - Special operands: done 2 clocks after the accepted start edge.
- Flags are valid with done and held with out until the next done; they are not sticky across operations.
- done is never asserted for two consecutive cycles.

Test Plan:
- in1=32'h40C00000 (6.0), in2=32'h40000000 (2.0), start pulse → done at clock 28, out=32'h40400000, all flags 0; busy high clocks 1–27.
- in1=32'h3F800000 (1.0), in2=32'h40400000 (3.0) → out=32'h3EAAAAAB (RNE round-up verified); then 32'h3F800000/32'h3F800000 → 32'h3F800000.
- Specials, each with done at clock 2:
  - 32'hBF800000/32'h00000000 → 32'hFF800000, div_zero=1.
  - 0/0 → 32'h7FC00000, invalid=1.
  - 32'h7F800000/32'h7F800000 → 32'h7FC00000, invalid=1.
  - 32'h40000000/32'h7F800000 → 32'h00000000.
- Range limits:
  - 32'h7F000000/32'h3E800000 → 32'h7F800000, overflow=1.
  - 32'h00800000/32'h4F000000 → 32'h00000000, underflow=1.
- Second start pulsed at clock 10 with different operands → ignored; first result unchanged at clock 28.
- Back-to-back: start held high through the done cycle → second op accepted there, its done 28 clocks later.
- rst asserted at clock 15 → busy=0, done=0, out=0 immediately (async); no done follows; a new start afterward completes normally.
